// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift/rotate sequencer: one single-bit step per clock, result
// presented with a one-cycle done pulse.
module shift_seq_ctrl #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [CNT_W-1:0] shamt,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] out_data,
   output logic             done,
   output logic             busy
);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   localparam logic [1:0] OpRol = 2'b00;
   localparam logic [1:0] OpSll = 2'b01;
   localparam logic [1:0] OpRor = 2'b10;
   localparam logic [1:0] OpSrl = 2'b11;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] step_val;

   always_comb begin
      step_val = acc_q;
      unique case (op_q)
         OpRol:   step_val = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]};
         OpSll:   step_val = {acc_q[WIDTH-2:0], 1'b0};
         OpRor:   step_val = {acc_q[0], acc_q[WIDTH-1:1]};
         OpSrl:   step_val = {1'b0, acc_q[WIDTH-1:1]};
         default: step_val = acc_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      out_d   = out_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               acc_d = in_data;
               cnt_d = shamt;
               op_d  = op;
               if (shamt == '0) begin
                  state_d = StDone;
                  out_d   = in_data;
               end else begin
                  state_d = StShift;
               end
            end
         end
         StShift: begin
            acc_d = step_val;
            cnt_d = cnt_q - CNT_W'(1);
            // count==1 means this edge applies the final step
            if (cnt_q == CNT_W'(1)) begin
               state_d = StDone;
               out_d   = step_val;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         acc_q   <= '0;
         cnt_q   <= '0;
         op_q    <= 2'b00;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         out_q   <= out_d;
      end
   end

   assign ready    = (state_q == StIdle);
   assign busy     = ~ready;
   assign done     = (state_q == StDone);
   assign out_data = out_q;

endmodule
